// File: rtl/difftest_commit_buffer.sv
// In-order retire FIFO feeding COMMIT_WIDTH registered difftest commit slots; slot 0 always carries the oldest entry.
// Define DIFFTEST_COMMIT_CNT_EN to add the 64-bit cnt_commit output (total instructions reported).
module difftest_commit_buffer #(
  parameter int         DEPTH        = 8,
  parameter int         COMMIT_WIDTH = 2,
  parameter logic [7:0] CORE_ID      = 8'd0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [7:0]                  in_special,
  input  logic                        in_skip,
  input  logic                        in_isRVC,
  input  logic                        in_rfwen,
  input  logic                        in_fpwen,
  input  logic [31:0]                 in_wpdest,
  input  logic [7:0]                  in_wdest,
  input  logic [63:0]                 in_pc,
  input  logic [31:0]                 in_instr,
  input  logic                        stall,
  output logic [7:0]                  out_coreid,
  output logic [COMMIT_WIDTH-1:0]     out_valid,
  output logic [8*COMMIT_WIDTH-1:0]   out_index,
  output logic [8*COMMIT_WIDTH-1:0]   out_special,
  output logic [COMMIT_WIDTH-1:0]     out_skip,
  output logic [COMMIT_WIDTH-1:0]     out_isRVC,
  output logic [COMMIT_WIDTH-1:0]     out_rfwen,
  output logic [COMMIT_WIDTH-1:0]     out_fpwen,
  output logic [32*COMMIT_WIDTH-1:0]  out_wpdest,
  output logic [8*COMMIT_WIDTH-1:0]   out_wdest,
  output logic [64*COMMIT_WIDTH-1:0]  out_pc,
`ifdef DIFFTEST_COMMIT_CNT_EN
  output logic [63:0]                 cnt_commit,
`endif
  output logic [32*COMMIT_WIDTH-1:0]  out_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 148;

  logic [EW-1:0]           mem_r [DEPTH];
  logic [PW-1:0]           wr_ptr_r;
  logic [PW-1:0]           rd_ptr_r;
  logic [EW-1:0]           slot_r [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] slot_valid_r;

  logic [PW-1:0]           count_s;
  logic [PW-1:0]           drain_n_s;
  logic                    enq_s;
  logic [EW-1:0]           entry_in_s;
  logic [AW-1:0]           rd_idx_s [COMMIT_WIDTH];

  // Entry layout: special, flags, wpdest, wdest, pc, instr (instr at the LSB end)
  assign entry_in_s = {in_special, in_skip, in_isRVC, in_rfwen, in_fpwen,
                       in_wpdest, in_wdest, in_pc, in_instr};

  assign count_s  = wr_ptr_r - rd_ptr_r;
  assign in_ready = (count_s < PW'(DEPTH));
  assign enq_s    = in_valid && in_ready;

  // Number of entries drained this cycle
  always_comb begin
    drain_n_s = '0;
    if (stall) begin
      drain_n_s = '0;
    end else if (count_s < PW'(COMMIT_WIDTH)) begin
      drain_n_s = count_s;
    end else begin
      drain_n_s = PW'(COMMIT_WIDTH);
    end
  end

  // Storage index of the k-th oldest entry
  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      rd_idx_s[k] = rd_ptr_r[AW-1:0] + AW'(k);
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (enq_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= entry_in_s;
        wr_ptr_r                <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r <= rd_ptr_r + drain_n_s;
    end
  end

  // Commit slots: undrained slots drop valid but keep their last data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid_r <= '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        slot_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (PW'(k) < drain_n_s) begin
          slot_r[k]       <= mem_r[rd_idx_s[k]];
          slot_valid_r[k] <= 1'b1;
        end else begin
          slot_valid_r[k] <= 1'b0;
        end
      end
    end
  end

`ifdef DIFFTEST_COMMIT_CNT_EN
  logic [63:0] cnt_commit_r;

  // Running total of reported instructions, wraps modulo 2^64
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_commit_r <= 64'd0;
    end else begin
      cnt_commit_r <= cnt_commit_r + 64'(drain_n_s);
    end
  end

  assign cnt_commit = cnt_commit_r;
`endif

  assign out_coreid = CORE_ID;
  assign out_valid  = slot_valid_r;

  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_slot
    assign out_index[8*k +: 8]    = 8'(k);
    assign out_special[8*k +: 8]  = slot_r[k][147:140];
    assign out_skip[k]            = slot_r[k][139];
    assign out_isRVC[k]           = slot_r[k][138];
    assign out_rfwen[k]           = slot_r[k][137];
    assign out_fpwen[k]           = slot_r[k][136];
    assign out_wpdest[32*k +: 32] = slot_r[k][135:104];
    assign out_wdest[8*k +: 8]    = slot_r[k][103:96];
    assign out_pc[64*k +: 64]     = slot_r[k][95:32];
    assign out_instr[32*k +: 32]  = slot_r[k][31:0];
  end

endmodule

// File: tb/tb_difftest_commit_buffer.sv
// Scoreboard bench for difftest_commit_buffer: accepted entries are queued, the monitor pops them as slots report.
module tb_difftest_commit_buffer;

  localparam int CW = 2;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_special;
  logic          in_skip;
  logic          in_isRVC;
  logic          in_rfwen;
  logic          in_fpwen;
  logic [31:0]   in_wpdest;
  logic [7:0]    in_wdest;
  logic [63:0]   in_pc;
  logic [31:0]   in_instr;
  logic          stall;
  logic [7:0]    out_coreid;
  logic [CW-1:0] out_valid;
  logic [8*CW-1:0]  out_index;
  logic [8*CW-1:0]  out_special;
  logic [CW-1:0]    out_skip;
  logic [CW-1:0]    out_isRVC;
  logic [CW-1:0]    out_rfwen;
  logic [CW-1:0]    out_fpwen;
  logic [32*CW-1:0] out_wpdest;
  logic [8*CW-1:0]  out_wdest;
  logic [64*CW-1:0] out_pc;
  logic [32*CW-1:0] out_instr;
`ifdef DIFFTEST_COMMIT_CNT_EN
  logic [63:0]      cnt_commit;
`endif

  difftest_commit_buffer #(.DEPTH(8), .COMMIT_WIDTH(CW), .CORE_ID(8'd0)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_special(in_special), .in_skip(in_skip), .in_isRVC(in_isRVC),
    .in_rfwen(in_rfwen), .in_fpwen(in_fpwen), .in_wpdest(in_wpdest),
    .in_wdest(in_wdest), .in_pc(in_pc), .in_instr(in_instr),
    .stall(stall), .out_coreid(out_coreid), .out_valid(out_valid),
    .out_index(out_index), .out_special(out_special), .out_skip(out_skip),
    .out_isRVC(out_isRVC), .out_rfwen(out_rfwen), .out_fpwen(out_fpwen),
    .out_wpdest(out_wpdest), .out_wdest(out_wdest), .out_pc(out_pc),
`ifdef DIFFTEST_COMMIT_CNT_EN
    .cnt_commit(cnt_commit),
`endif
    .out_instr(out_instr)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [147:0] sb_q[$];
  logic [63:0]  next_pc;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive all fields from the pc so each entry is distinguishable
  task automatic drive_fields(input logic [63:0] pc);
    in_pc      = pc;
    in_instr   = {pc[13:2], 20'h00013};
    in_special = pc[9:2] ^ 8'h5a;
    in_skip    = pc[2];
    in_isRVC   = pc[3];
    in_rfwen   = pc[4];
    in_fpwen   = pc[5];
    in_wdest   = pc[9:2];
    in_wpdest  = {pc[31:2], 2'b01};
  endtask

  task automatic step(input logic v, input logic st);
    in_valid = v;
    stall    = st;
    drive_fields(next_pc);
    if (v && in_ready) begin
      sb_q.push_back({in_special, in_skip, in_isRVC, in_rfwen, in_fpwen,
                      in_wpdest, in_wdest, in_pc, in_instr});
      next_pc = next_pc + 64'd4;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    stall    = 1'b0;
    tick();
    tick();
    sb_q.delete();
    #2;
    reset   = 1'b1;
    next_pc = 64'h8000_0000;
    tick();
  endtask

  // Monitor: every valid slot must match the oldest outstanding accepted entry
  always @(posedge clock) begin
    #1;
    if (reset && (out_valid != '0)) begin
      check_eq("valid_contig", {159'd0, out_valid == 2'b10}, 160'd0);
      for (int k = 0; k < CW; k++) begin
        if (out_valid[k]) begin
          if (sb_q.size() == 0) begin
            check_eq("sb_underflow", 160'd1, 160'd0);
          end else begin
            logic [147:0] exp_e;
            exp_e = sb_q.pop_front();
            check_eq($sformatf("slot%0d_pc", k), {96'd0, out_pc[64*k +: 64]}, {96'd0, exp_e[95:32]});
            check_eq($sformatf("slot%0d_entry", k),
                     {12'd0, out_special[8*k +: 8], out_skip[k], out_isRVC[k], out_rfwen[k],
                      out_fpwen[k], out_wpdest[32*k +: 32], out_wdest[8*k +: 8],
                      out_pc[64*k +: 64], out_instr[32*k +: 32]},
                     {12'd0, exp_e});
          end
        end
      end
    end
  end

  initial begin
    int accepted;
    int guard;
    reset = 1'b0; in_valid = 1'b0; stall = 1'b0; next_pc = 64'h8000_0000;
    drive_fields(64'd0);
    tick();
    tick();
    check_eq("rst_valid", {158'd0, out_valid}, 160'd0);
    check_eq("rst_pc", {32'd0, out_pc}, 160'd0);
    #2 reset = 1'b1;
    tick();
    check_eq("rst_ready", {159'd0, in_ready}, 160'd1);
    check_eq("coreid", {152'd0, out_coreid}, 160'd0);
    check_eq("index", {144'd0, out_index}, {144'd0, 16'h0100});
`ifdef DIFFTEST_COMMIT_CNT_EN
    check_eq("rst_cnt", {96'd0, cnt_commit}, 160'd0);
`endif

    // Single instruction
    step(1'b1, 1'b0);
    check_eq("single_pre", {158'd0, out_valid}, 160'd0);
    step(1'b0, 1'b0);
    check_eq("single_valid", {158'd0, out_valid}, {158'd0, 2'b01});
    check_eq("single_pc", {96'd0, out_pc[63:0]}, {96'd0, 64'h8000_0000});
    check_eq("single_instr", {128'd0, out_instr[31:0]}, {128'd0, 32'h0000_0013});
    step(1'b0, 1'b0);
    check_eq("single_pulse", {158'd0, out_valid}, 160'd0);

    // Burst of 5 back-to-back retires: one per cycle on slot 0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      check_eq("burst_valid", {158'd0, out_valid}, (i == 0) ? 160'd0 : {158'd0, 2'b01});
    end
    step(1'b0, 1'b0);
    check_eq("burst_last", {158'd0, out_valid}, {158'd0, 2'b01});
    step(1'b0, 1'b0);
    check_eq("burst_idle", {158'd0, out_valid}, 160'd0);
`ifdef DIFFTEST_COMMIT_CNT_EN
    check_eq("burst_cnt", {96'd0, cnt_commit}, {96'd0, 64'd5});
`endif

    // Fill under stall, hold a 9th, then release
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      check_eq("fill_ready", {159'd0, in_ready}, (i == 7) ? 160'd0 : 160'd1);
    end
    step(1'b1, 1'b1);
    check_eq("held_ready", {159'd0, in_ready}, 160'd0);
    check_eq("held_valid", {158'd0, out_valid}, 160'd0);
    step(1'b1, 1'b0);
    check_eq("rel_valid0", {158'd0, out_valid}, {158'd0, 2'b11});
    check_eq("rel_ready", {159'd0, in_ready}, 160'd1);
    step(1'b1, 1'b0);
    check_eq("rel_valid1", {158'd0, out_valid}, {158'd0, 2'b11});
    step(1'b0, 1'b0);
    check_eq("rel_valid2", {158'd0, out_valid}, {158'd0, 2'b11});
    step(1'b0, 1'b0);
    check_eq("rel_valid3", {158'd0, out_valid}, {158'd0, 2'b11});
    step(1'b0, 1'b0);
    check_eq("rel_ninth", {158'd0, out_valid}, {158'd0, 2'b01});
    step(1'b0, 1'b0);
    check_eq("rel_idle", {158'd0, out_valid}, 160'd0);

    // Odd count drain
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_eq("odd_a", {158'd0, out_valid}, {158'd0, 2'b11});
    step(1'b0, 1'b0);
    check_eq("odd_b", {158'd0, out_valid}, {158'd0, 2'b01});
    step(1'b0, 1'b0);
    check_eq("odd_c", {158'd0, out_valid}, 160'd0);

    // Reset mid-drain with entries still buffered
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check_eq("mid_pre", {158'd0, out_valid}, {158'd0, 2'b11});
    #2 reset = 1'b0;
    #1;
    check_eq("mid_async_valid", {158'd0, out_valid}, 160'd0);
    check_eq("mid_async_pc", {32'd0, out_pc}, 160'd0);
    sb_q.delete();
    tick();
    #2 reset = 1'b1;
    next_pc = 64'h9000_0000;
    tick();
    check_eq("mid_ready", {159'd0, in_ready}, 160'd1);
    step(1'b0, 1'b0);
    check_eq("mid_empty", {158'd0, out_valid}, 160'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("mid_alone", {158'd0, out_valid}, {158'd0, 2'b01});
    check_eq("mid_pc", {96'd0, out_pc[63:0]}, {96'd0, 64'h9000_0000});

    // Wrap: 20 entries with random valid/stall, scoreboard checks order
    do_reset();
    accepted = 0;
    guard = 0;
    while (accepted < 20 && guard < 500) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      if (v && in_ready) accepted++;
      step(v, $urandom_range(0, 3) == 0);
      guard++;
    end
    check_eq("wrap_accepted", 160'(accepted), 160'd20);
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      step(1'b0, 1'b0);
      guard++;
    end
    step(1'b0, 1'b0);
    check_eq("wrap_drained", 160'(sb_q.size()), 160'd0);
    check_eq("wrap_idle", {158'd0, out_valid}, 160'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
